// File: rtl/islip_accept_stage.sv
// islip_accept_stage
//   Accept phase of the op-iSLIP switch allocator. Each of P inputs takes
//   up to N output grants and accepts one of them. The choice is the first
//   granted output found by a round-robin scan that starts at the input's
//   accept pointer. The accept matrix is registered and uses the same bit
//   layout as the grant matrix. This block owns both pointer arrays: the
//   per-input accept pointers and the per-output grant pointers. Pointers
//   move only on first-iteration accepts. The grant pointers are exported
//   back to the grant stage.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   i_valid        i_grant is valid this cycle
//   i_first_iter   qualifies i_valid for pointer updates
//   i_grant        P*N, bit j*N+i set = output i grants input j
//   i_clear        synchronous clear of all pointers (wins over updates)
//   o_valid        o_accept / o_match_cnt valid (1-cycle latency)
//   o_accept       P*N, bit j*N+i set = input j accepts output i
//   o_match_cnt    number of inputs that accepted
//   o_accept_ptr   accept pointer of input j at [j*AW +: AW]
//   o_grant_ptr    grant pointer of output i at [i*GW +: GW]
module islip_accept_stage #(
    parameter  int N  = 25,
    parameter  int P  = 8,
    localparam int AW = (N > 1) ? $clog2(N) : 1,
    localparam int GW = (P > 1) ? $clog2(P) : 1,
    localparam int CW = $clog2(P + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_valid,
    input  logic            i_first_iter,
    input  logic [P*N-1:0]  i_grant,
    input  logic            i_clear,
    output logic            o_valid,
    output logic [P*N-1:0]  o_accept,
    output logic [CW-1:0]   o_match_cnt,
    output logic [P*AW-1:0] o_accept_ptr,
    output logic [N*GW-1:0] o_grant_ptr
);

    logic [AW-1:0]  a_q     [P];
    logic [GW-1:0]  g_q     [N];

    logic [P-1:0]   acc_hit;
    logic [AW-1:0]  acc_idx [P];
    logic [AW-1:0]  a_nxt   [P];
    logic [P*N-1:0] acc_vec;
    logic [CW-1:0]  acc_cnt;

    logic [N-1:0]   g_en;
    logic [GW-1:0]  g_nxt   [N];

    // Round-robin accept. The scan offset runs 0..N-1 from the pointer.
    // The first hit in that order is latched and later hits are ignored.
    always_comb begin
        int unsigned k;
        k       = 0;
        acc_hit = '0;
        acc_vec = '0;
        acc_cnt = '0;
        for (int unsigned j = 0; j < P; j++) begin
            acc_idx[j] = '0;
            a_nxt[j]   = '0;
            for (int unsigned off = 0; off < N; off++) begin
                k = 32'(a_q[j]) + off;
                if (k >= N) begin
                    k = k - N;
                end
                if (!acc_hit[j] && i_grant[j*N + k]) begin
                    acc_hit[j] = 1'b1;
                    acc_idx[j] = AW'(k);
                end
            end
            if (acc_hit[j]) begin
                acc_vec[j*N + 32'(acc_idx[j])] = 1'b1;
            end
            a_nxt[j] = (32'(acc_idx[j]) == N - 1) ? '0 : acc_idx[j] + AW'(1);
            acc_cnt  = acc_cnt + CW'(acc_hit[j]);
        end
    end

    // Grant pointer of output k follows the lowest input that accepted k.
    // If the grant is malformed, several inputs may accept the same output.
    // The ascending scan with an "already taken" flag makes the lowest j win.
    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            g_en[k]  = 1'b0;
            g_nxt[k] = '0;
            for (int unsigned j = 0; j < P; j++) begin
                if (!g_en[k] && acc_hit[j] && 32'(acc_idx[j]) == k) begin
                    g_en[k]  = 1'b1;
                    g_nxt[k] = (j == P - 1) ? '0 : GW'(j + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned j = 0; j < P; j++) a_q[j] <= '0;
            for (int unsigned k = 0; k < N; k++) g_q[k] <= '0;
        end else if (i_clear) begin
            for (int unsigned j = 0; j < P; j++) a_q[j] <= '0;
            for (int unsigned k = 0; k < N; k++) g_q[k] <= '0;
        end else if (i_valid && i_first_iter) begin
            for (int unsigned j = 0; j < P; j++) begin
                if (acc_hit[j]) a_q[j] <= a_nxt[j];
            end
            for (int unsigned k = 0; k < N; k++) begin
                if (g_en[k]) g_q[k] <= g_nxt[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid     <= 1'b0;
            o_accept    <= '0;
            o_match_cnt <= '0;
        end else begin
            o_valid     <= i_valid;
            o_accept    <= i_valid ? acc_vec : '0;
            o_match_cnt <= i_valid ? acc_cnt : '0;
        end
    end

    always_comb begin
        o_accept_ptr = '0;
        o_grant_ptr  = '0;
        for (int unsigned j = 0; j < P; j++) o_accept_ptr[j*AW +: AW] = a_q[j];
        for (int unsigned k = 0; k < N; k++) o_grant_ptr[k*GW +: GW]  = g_q[k];
    end

endmodule
